// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared types and reset constants for the clk_div_multi generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int DIV_RST  = 2;
    localparam int HIGH_RST = 1;
    localparam int DIV_MIN  = 2;

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// Module   : clk_div_chan
// Brief    : One generator channel: phase counter, active/shadow period and
//            high time, pending flag. High-time registers exist only when
//            CLKGEN_DUTY_EN is defined; otherwise high time is half the period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DW = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [DW-1:0] i_cfg_div,
    input  logic [DW-1:0] i_cfg_high,
    input  logic          i_en,
    input  logic          i_sync,
    output logic          o_pend,
    output logic          o_sig,
    output logic          o_tick
);

    chan_state_e   r_state;
    chan_state_e   w_state_nxt;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] r_div_s;
    logic          r_pend;
    logic          r_sig;
    logic          r_tick;

    logic [DW-1:0] w_div_clamp;
    logic          w_wrap;
    logic          w_apply;
    logic [DW-1:0] w_div_eff;
    logic [DW-1:0] w_high_eff;
    logic [DW-1:0] w_nxt;
    logic [DW-1:0] w_cnt_nxt;
    logic          w_sig_nxt;
    logic          w_tick_nxt;

    assign w_div_clamp = (i_cfg_div < DW'(DIV_MIN)) ? DW'(DIV_MIN) : i_cfg_div;
    assign w_wrap      = i_sync || (r_cnt == r_div - DW'(1));
    // Shadow values move to active only at a phase-0 edge, or straight away in IDLE.
    assign w_apply     = r_pend && ((r_state == IDLE) || (i_en && w_wrap));
    assign w_div_eff   = w_apply ? r_div_s : r_div;
    assign w_nxt       = w_wrap ? '0 : r_cnt + DW'(1);

`ifdef CLKGEN_DUTY_EN
    logic [DW-1:0] r_high;
    logic [DW-1:0] r_high_s;

    assign w_high_eff = w_apply ? r_high_s : r_high;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_high   <= DW'(HIGH_RST);
            r_high_s <= DW'(HIGH_RST);
        end else begin
            if (i_wr)
                r_high_s <= i_cfg_high;
            if (w_apply)
                r_high <= r_high_s;
        end
    end
`else
    logic w_unused_high;

    assign w_unused_high = ^i_cfg_high;
    assign w_high_eff    = w_div_eff >> 1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sig_nxt   = 1'b0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (i_en) begin
                    w_state_nxt = RUN;
                    w_sig_nxt   = (w_high_eff != '0);
                    w_tick_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt  = w_nxt;
                    w_sig_nxt  = (w_nxt < w_high_eff);
                    w_tick_nxt = (w_nxt == '0);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= DW'(DIV_RST);
            r_div_s <= DW'(DIV_RST);
            r_pend  <= 1'b0;
            r_sig   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sig  <= w_sig_nxt;
            r_tick <= w_tick_nxt;
            if (i_wr)
                r_div_s <= w_div_clamp;
            if (w_apply)
                r_div <= r_div_s;
            if (i_wr)
                r_pend <= 1'b1;
            else if (w_apply)
                r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_sig  = r_sig;
    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Brief    : NCH-channel programmable clock/strobe generator on clk_50M.
//            Optional per-channel high time enabled by CLKGEN_DUTY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int DW  = 25,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_50M,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    input  logic [DW-1:0]  cfg_high,
    input  logic [NCH-1:0] en,
    input  logic           sync_in,
    output logic [NCH-1:0] sig_out,
    output logic [NCH-1:0] tick
);

    logic [NCH-1:0] w_pend;
    logic           w_accept;

    // Unmapped channel numbers report ready; their writes decode to nothing.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i))
                cfg_ready = !w_pend[i];
        end
    end

    assign w_accept = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic w_wr;

        assign w_wr = w_accept && (cfg_ch == CHW'(gi));

        clk_div_chan #(
            .DW (DW)
        ) u_chan (
            .clk        (clk_50M),
            .rst        (rst),
            .i_wr       (w_wr),
            .i_cfg_div  (cfg_div),
            .i_cfg_high (cfg_high),
            .i_en       (en[gi]),
            .i_sync     (sync_in),
            .o_pend     (w_pend[gi]),
            .o_sig      (sig_out[gi]),
            .o_tick     (tick[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed self-checking bench for clk_div_multi (both builds of
//            CLKGEN_DUTY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int DW  = 25;
    localparam int BASIC_H =
`ifdef CLKGEN_DUTY_EN
        2;
`else
        4;
`endif

    logic           clk_50M = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic [DW-1:0]  cfg_high = '0;
    logic [NCH-1:0] en = '0;
    logic           sync_in = 1'b0;
    logic [NCH-1:0] sig_out;
    logic [NCH-1:0] tick;

    int n_vec = 0;
    int n_err = 0;

    clk_div_multi #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .en        (en),
        .sync_in   (sync_in),
        .sig_out   (sig_out),
        .tick      (tick)
    );

    always #10 clk_50M = ~clk_50M;

    // Effective high time seen on the output for a (clamped) period d.
    function automatic int hx(input int d, input int h);
`ifdef CLKGEN_DUTY_EN
        return h + (d * 0);
`else
        return (d / 2) + (h * 0);
`endif
    endfunction

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_phase(input int ch, input int ph, input int d, input int h);
        chk($sformatf("sig%0d_ph%0d_d%0d", ch, ph, d), 32'(sig_out[ch]), 32'(ph < h));
        chk($sformatf("tick%0d_ph%0d_d%0d", ch, ph, d), 32'(tick[ch]), 32'(ph == 0));
    endtask

    task automatic cfg_write(input int ch, input int d, input int h);
        cfg_ch    = 2'(ch);
        cfg_div   = DW'(d);
        cfg_high  = DW'(h);
        cfg_valid = 1'b1;
        chk($sformatf("ready_before_wr%0d", ch), 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    // Park the channel in IDLE, load new settings, then enable; returns at phase 0.
    task automatic cfg_and_start(input int ch, input int d, input int h);
        en[ch] = 1'b0;
        step();
        chk($sformatf("idle_sig%0d", ch), 32'(sig_out[ch]), 32'd0);
        chk($sformatf("idle_tick%0d", ch), 32'(tick[ch]), 32'd0);
        cfg_write(ch, d, h);
        chk($sformatf("idle_pend%0d", ch), 32'(cfg_ready), 32'd0);
        step();
        chk($sformatf("idle_apply%0d", ch), 32'(cfg_ready), 32'd1);
        en[ch] = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_sig", 32'(sig_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Basic waveform D=5
        cfg_and_start(0, 5, BASIC_H);
        for (int k = 0; k < 10; k++) begin
            expect_phase(0, k % 5, 5, hx(5, BASIC_H));
            step();
        end

        // Mid-period update at phase 2 to D=8 H=4
        step();
        step();
        expect_phase(0, 2, 5, hx(5, BASIC_H));
        cfg_write(0, 8, 4);
        chk("mid_ready_ph3", 32'(cfg_ready), 32'd0);
        cfg_ch = 2'd1;
        #1;
        chk("other_ch_ready", 32'(cfg_ready), 32'd1);
        cfg_ch = 2'd0;
        #1;
        expect_phase(0, 3, 5, hx(5, BASIC_H));
        step();
        chk("mid_ready_ph4", 32'(cfg_ready), 32'd0);
        expect_phase(0, 4, 5, hx(5, BASIC_H));
        step();
        chk("mid_ready_wrap", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 16; k++) begin
            expect_phase(0, k % 8, 8, hx(8, 4));
            step();
        end

        // Duty extremes and divisor clamp
        cfg_and_start(0, 3, 0);
        for (int k = 0; k < 6; k++) begin
            expect_phase(0, k % 3, 3, hx(3, 0));
            step();
        end
        cfg_and_start(0, 6, 9);
        for (int k = 0; k < 12; k++) begin
            expect_phase(0, k % 6, 6, hx(6, 9));
            step();
        end
        cfg_and_start(0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            expect_phase(0, k % 2, 2, hx(2, 1));
            step();
        end

        // Phase alignment: ch0 D=4, ch1 D=6 started three cycles later
        cfg_and_start(1, 6, 3);
        en[1] = 1'b0;
        step();
        cfg_and_start(0, 4, 2);
        expect_phase(0, 0, 4, hx(4, 2));
        step();
        step();
        en[1] = 1'b1;
        step();
        expect_phase(0, 3, 4, hx(4, 2));
        expect_phase(1, 0, 6, hx(6, 3));
        step();
        expect_phase(0, 0, 4, hx(4, 2));
        expect_phase(1, 1, 6, hx(6, 3));
        step();
        expect_phase(0, 1, 4, hx(4, 2));
        expect_phase(1, 2, 6, hx(6, 3));
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        for (int k = 0; k < 24; k++) begin
            expect_phase(0, k % 4, 4, hx(4, 2));
            expect_phase(1, k % 6, 6, hx(6, 3));
            step();
        end

        // Reset at phase 3 of D=10 with a write pending
        en[1] = 1'b0;
        cfg_and_start(0, 10, 5);
        step();
        step();
        step();
        expect_phase(0, 3, 10, hx(10, 5));
        cfg_write(0, 7, 3);
        chk("pend_before_rst", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_sig", 32'(sig_out), 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        step();
        for (int k = 0; k < 6; k++) begin
            expect_phase(0, k % 2, 2, hx(2, 1));
            step();
        end

        // Drop enable mid-period while output is high
        cfg_and_start(0, 10, 8);
        step();
        step();
        expect_phase(0, 2, 10, hx(10, 8));
        en[0] = 1'b0;
        step();
        chk("dis_sig", 32'(sig_out[0]), 32'd0);
        chk("dis_tick", 32'(tick[0]), 32'd0);
        step();
        chk("dis_sig_hold", 32'(sig_out[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
